// File: rtl/plugboard_config.sv
// rtl/plugboard_config.sv - Enigma plugboard: programmable involutive swap table with registered lookups
module plugboard_config #(
    parameter int N_LETTERS = 26,
    parameter int CW        = 5,
    parameter int MAX_PAIRS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [CW-1:0] key_code,
    input  logic          clear,
    input  logic          lookup_valid,
    input  logic [CW-1:0] lookup_in,
    output logic          lookup_ready,
    output logic          lookup_vout,
    output logic [CW-1:0] lookup_out,
    output logic          pending,
    output logic [3:0]    pair_count,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SECOND = 2'd1,
        CLEARING    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_tab [N_LETTERS];
    logic [CW-1:0] r_first;
    logic [CW-1:0] r_idx;
    logic [3:0]    r_pair_count;
    logic          r_err;
    logic          r_vout;
    logic [CW-1:0] r_out;

    logic [CW-1:0] w_key_map;
    logic [CW-1:0] w_idx_map;
    logic [CW-1:0] w_lk_map;
    logic          w_key_ok;
    logic          w_lk_ok;
    logic          w_ready;
    logic          w_wa;
    logic [CW-1:0] w_wa_idx;
    logic [CW-1:0] w_wa_val;
    logic          w_wb;
    logic [CW-1:0] w_wb_idx;
    logic [CW-1:0] w_wb_val;
    logic          w_first_load;
    logic          w_pc_inc;
    logic          w_pc_dec;
    logic          w_pc_zero;
    logic          w_key_err;
    logic          w_err;

    assign w_key_ok = key_code < CW'(N_LETTERS);
    assign w_lk_ok  = lookup_in < CW'(N_LETTERS);
    assign w_ready  = (r_state != CLEARING);

    // Mux-style table reads keep out-of-range codes from ever indexing the array
    always_comb begin
        w_key_map = key_code;
        w_idx_map = r_idx;
        w_lk_map  = lookup_in;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (key_code == CW'(i))  w_key_map = r_tab[i];
            if (r_idx == CW'(i))     w_idx_map = r_tab[i];
            if (lookup_in == CW'(i)) w_lk_map  = r_tab[i];
        end
    end

    always_comb begin
        w_next       = r_state;
        w_wa         = 1'b0;
        w_wa_idx     = '0;
        w_wa_val     = '0;
        w_wb         = 1'b0;
        w_wb_idx     = '0;
        w_wb_val     = '0;
        w_first_load = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_dec     = 1'b0;
        w_pc_zero    = 1'b0;
        w_key_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_next = CLEARING;
                end else if (key_valid) begin
                    if (!w_key_ok) begin
                        w_key_err = 1'b1;
                    end else if (w_key_map != key_code) begin
                        w_wa     = 1'b1;
                        w_wa_idx = key_code;
                        w_wa_val = key_code;
                        w_wb     = 1'b1;
                        w_wb_idx = w_key_map;
                        w_wb_val = w_key_map;
                        w_pc_dec = 1'b1;
                    end else if (r_pair_count == 4'(MAX_PAIRS)) begin
                        w_key_err = 1'b1;
                    end else begin
                        w_first_load = 1'b1;
                        w_next       = WAIT_SECOND;
                    end
                end
            end
            WAIT_SECOND: begin
                if (clear) begin
                    w_next = CLEARING;
                end else if (key_valid) begin
                    w_next = IDLE;
                    if (key_code == r_first) begin
                        w_next = IDLE;
                    end else if (!w_key_ok || w_key_map != key_code) begin
                        w_key_err = 1'b1;
                    end else begin
                        w_wa     = 1'b1;
                        w_wa_idx = r_first;
                        w_wa_val = key_code;
                        w_wb     = 1'b1;
                        w_wb_idx = key_code;
                        w_wb_val = r_first;
                        w_pc_inc = 1'b1;
                    end
                end
            end
            CLEARING: begin
                // Unplug the whole pair at the index so the table stays involutive mid-clear
                w_wa     = 1'b1;
                w_wa_idx = r_idx;
                w_wa_val = r_idx;
                w_wb     = 1'b1;
                w_wb_idx = w_idx_map;
                w_wb_val = w_idx_map;
                if (!clear && r_idx == CW'(N_LETTERS - 1)) begin
                    w_next    = IDLE;
                    w_pc_zero = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_err = w_key_err | (lookup_valid & (!w_ready | !w_lk_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_first      <= '0;
            r_idx        <= '0;
            r_pair_count <= '0;
            r_err        <= 1'b0;
            r_vout       <= 1'b0;
            r_out        <= '0;
            for (int i = 0; i < N_LETTERS; i++) r_tab[i] <= CW'(i);
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
            if (w_first_load) r_first <= key_code;
            if (clear)                   r_idx <= '0;
            else if (r_state == CLEARING) r_idx <= r_idx + CW'(1);
            if (w_pc_zero)     r_pair_count <= '0;
            else if (w_pc_inc) r_pair_count <= r_pair_count + 4'd1;
            else if (w_pc_dec) r_pair_count <= r_pair_count - 4'd1;
            for (int i = 0; i < N_LETTERS; i++) begin
                if (w_wa && w_wa_idx == CW'(i)) r_tab[i] <= w_wa_val;
                if (w_wb && w_wb_idx == CW'(i)) r_tab[i] <= w_wb_val;
            end
            r_vout <= lookup_valid & w_ready;
            if (lookup_valid && w_ready) r_out <= w_lk_ok ? w_lk_map : lookup_in;
        end
    end

    assign lookup_ready = w_ready;
    assign lookup_vout  = r_vout;
    assign lookup_out   = r_out;
    assign pending      = (r_state == WAIT_SECOND);
    assign pair_count   = r_pair_count;
    assign err          = r_err;

endmodule

// File: tb/tb_plugboard_config.sv
// tb/tb_plugboard_config.sv - scoreboard bench for plugboard_config
module tb_plugboard_config;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [4:0] key_code = '0;
    logic       clear = 1'b0;
    logic       lookup_valid = 1'b0;
    logic [4:0] lookup_in = '0;
    logic       lookup_ready;
    logic       lookup_vout;
    logic [4:0] lookup_out;
    logic       pending;
    logic [3:0] pair_count;
    logic       err;

    int n_pass = 0;
    int n_total = 0;
    int err_cnt = 0;
    int e0;
    int cnt;
    logic [4:0] exp_q [$];

    plugboard_config dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .clear(clear), .lookup_valid(lookup_valid), .lookup_in(lookup_in),
        .lookup_ready(lookup_ready), .lookup_vout(lookup_vout), .lookup_out(lookup_out),
        .pending(pending), .pair_count(pair_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_cnt++;
            if (lookup_vout) begin
                if (exp_q.size() == 0) check("unexpected_vout", 1, 0);
                else check("lookup_out", int'(lookup_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic lookup(input logic [4:0] li, input logic [4:0] want);
        lookup_valid = 1'b1;
        lookup_in    = li;
        exp_q.push_back(want);
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic pair(input logic [4:0] a, input logic [4:0] b);
        key(a);
        key(b);
    endtask

    initial begin
        tick(2);
        check("rst_vout", lookup_vout, 0);
        check("rst_out", lookup_out, 0);
        check("rst_pending", pending, 0);
        check("rst_pc", pair_count, 0);
        check("rst_err", err, 0);
        check("rst_ready", lookup_ready, 1);
        rst_n = 1'b1;
        tick();

        // 1: identity table, back-to-back lookups
        for (int i = 0; i < 26; i++) lookup(5'(i), 5'(i));
        tick(2);
        check("t1_pc", pair_count, 0);
        check("t1_drained", exp_q.size(), 0);

        // 2: pair A-E
        e0 = err_cnt;
        pair(0, 4);
        check("t2_pc", pair_count, 1);
        lookup(0, 4);
        lookup(4, 0);
        lookup(1, 1);
        tick(2);

        // 3: unplug via E
        key(4);
        lookup(0, 0);
        tick(2);
        check("t3_pc", pair_count, 0);
        check("t3_noerr", err_cnt - e0, 0);

        // 4: second key already plugged; out-of-range key
        pair(4, 16);
        key(0);
        check("t4_pending", pending, 1);
        e0 = err_cnt;
        key(4);
        tick();
        check("t4_err", err_cnt - e0, 1);
        check("t4_idle", pending, 0);
        lookup(0, 0);
        lookup(4, 16);
        lookup(16, 4);
        e0 = err_cnt;
        key(27);
        tick();
        check("t4_key27_err", err_cnt - e0, 1);
        check("t4_key27_idle", pending, 0);
        e0 = err_cnt;
        lookup(29, 29);
        tick();
        check("t4_lk29_err", err_cnt - e0, 1);

        // 5: fill to 10 pairs, overflow, then clear
        pair(0, 1);  pair(2, 3);  pair(5, 6);  pair(7, 8);  pair(9, 10);
        pair(11, 12); pair(13, 14); pair(15, 17); pair(18, 19);
        check("t5_pc10", pair_count, 10);
        lookup(15, 17);
        lookup(19, 18);
        e0 = err_cnt;
        key(20);
        tick();
        check("t5_full_err", err_cnt - e0, 1);
        check("t5_pc_hold", pair_count, 10);
        check("t5_no_pending", pending, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        e0 = err_cnt;
        cnt = 0;
        while (!lookup_ready && cnt < 40) begin
            lookup_valid = (cnt == 3);
            lookup_in    = 5'd2;
            key_valid    = (cnt == 5);
            key_code     = 5'd21;
            cnt++;
            tick();
        end
        lookup_valid = 1'b0;
        key_valid    = 1'b0;
        tick();
        check("t5_clear_cycles", cnt, 26);
        check("t5_clear_err", err_cnt - e0, 1);
        check("t5_pc0", pair_count, 0);
        for (int i = 0; i < 26; i++) lookup(5'(i), 5'(i));
        tick(2);

        // 6: clear beats key in WAIT_SECOND; lookup sees pre-write entry
        key(0);
        check("t6_pending", pending, 1);
        e0 = err_cnt;
        clear = 1'b1;
        key_valid = 1'b1;
        key_code = 5'd4;
        tick();
        clear = 1'b0;
        key_valid = 1'b0;
        check("t6_pending_cleared", pending, 0);
        check("t6_ready_low", lookup_ready, 0);
        cnt = 0;
        while (!lookup_ready && cnt < 40) begin
            cnt++;
            tick();
        end
        check("t6_clear_cycles", cnt, 26);
        check("t6_noerr", err_cnt - e0, 0);
        check("t6_pc0", pair_count, 0);
        lookup(0, 0);
        key(0);
        key_valid = 1'b1;
        key_code = 5'd4;
        lookup_valid = 1'b1;
        lookup_in = 5'd0;
        exp_q.push_back(5'd0);
        tick();
        key_valid = 1'b0;
        lookup_valid = 1'b0;
        lookup(0, 4);
        tick(2);
        check("t6_pc1", pair_count, 1);

        // reset in the middle of CLEARING
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", lookup_ready, 1);
        check("rst_mid_pc", pair_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        lookup(0, 0);
        tick(2);
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
